uart_rx_os16: RTL
=================

UART_RX_OS16 -- requirements
Module: uart_rx_os16

Interface
REQ-001 SHALL have parameter OS_DIV, default 326; clk cycles per 1/16-bit tick (50 MHz / (9600*16), rounded).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz; only clock in the block.
REQ-003 SHALL have port clr  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port rxd  input  1  asynchronous serial line; idles high; 8N1 framing, LSB first.
REQ-005 SHALL have port data  output  8  last correctly framed byte received.
REQ-006 SHALL have port valid  output  1  one-cycle pulse when data updates.
REQ-007 SHALL have port frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port sent_switch  output  1  level; enable for the periodic transmitter.

Function
REQ-010 SHALL pass rxd through a 2-FF synchronizer, both flops reset to 1; all logic uses the synchronized value rxs.
REQ-011 SHALL implement a prescaler counting 0..OS_DIV-1 that emits tick for one cycle at OS_DIV-1, then wraps to 0.
REQ-012 SHALL hold the prescaler and the 4-bit tick counter at 0 while in IDLE, so bit timing aligns to the start edge.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: rxs==0 -> START; otherwise remain.
REQ-015 START: on the 8th tick (mid start bit), rxs==1 -> IDLE (glitch, no pulse); rxs==0 -> DATA with tick counter and bit index cleared.
REQ-016 DATA: on every 16th tick, shift rxs into the shift register MSB end (LSB-first assembly) and increment the 3-bit bit index; after the 8th sample -> STOP.
REQ-017 STOP: on the 16th tick, rxs==1 -> load data from the shift register, pulse valid, go IDLE; rxs==0 -> pulse frame_err, keep data, go BREAK.
REQ-018 BREAK: remain until rxs==1, then go IDLE; no pulses while in BREAK.
REQ-019 SHALL assert valid or frame_err exactly one clk cycle after the stop-bit sampling tick; never both in the same cycle.
REQ-020 SHALL update sent_switch only with valid: set to 1 if the new byte has bits [7:6]==2'b00, else 0; a frame error leaves it unchanged.
REQ-021 Nominal latency, start-bit falling edge (at rxs) to valid: 9.5 bit times + 1 cycle = 152*OS_DIV + 1 clk.
REQ-022 A new start edge in the cycle after valid SHALL be accepted; back-to-back frames with one stop bit SHALL lose no byte.
REQ-023 Tick counter and bit index SHALL wrap modulo their widths; no saturation logic.

Reset
REQ-024 clr high at a clk edge SHALL force state IDLE, prescaler 0, tick counter 0, bit index 0, shift register 0, data 8'h00, valid 0, frame_err 0, busy 0, sent_switch 0, synchronizer flops 1.
REQ-025 clr asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception resumes at the next falling edge after clr deasserts.
REQ-026 clr SHALL take priority over every other event in the same cycle.

Verification (OS_DIV=4, 64 clk per bit)
REQ-027 Byte 8'hA5, stop high -> one valid pulse, data==8'hA5, frame_err never high, sent_switch==0.
REQ-028 Byte 8'h3C, then byte 8'hC3, back-to-back -> two valid pulses, 160*4 clk apart; data 3C then C3; sent_switch goes 1 then 0.
REQ-029 20-clk low glitch on an idle line -> back to IDLE at the mid-start sample, no valid, no frame_err, data unchanged.
REQ-030 Byte 8'h55 with stop bit low, line held low 200 clk, then high -> one frame_err pulse, data keeps its previous value, busy stays high until rxs returns to 1.
REQ-031 clr pulsed during bit 4 of 8'hFF, then 8'h12 sent -> no pulse for the aborted frame; valid with data==8'h12, sent_switch==1.
REQ-032 Latency check: measured clk count from the rxd falling edge to valid == 152*4 + 1 + 2 (synchronizer), with ±1 tolerance for edge phase.

Source files
------------

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver with 16x oversampling: mid-bit sampling, frame-error detection
// and a sent_switch level derived from the top two bits of each good byte.
module uart_rx_os16 #(
  parameter int unsigned OS_DIV = 326
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy,
  output logic       sent_switch
);

  localparam int unsigned PW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [PW-1:0] PreMax = PW'(OS_DIV - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e        state_q, state_d;
  logic          sync1_q, rxs;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ss_q, ss_d;

  logic tick, mid_start, sample_bit, stop_tick, stop_ok, stop_bad;

  // Prescaler is held at 0 in IDLE, so tick never fires there
  assign tick = (state_q != StIdle) && (pre_q == PreMax);

  // State register
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!rxs) state_d = StStart;
      StStart: if (mid_start) state_d = rxs ? StIdle : StData;
      StData:  if (sample_bit && (bidx_q == 3'd7)) state_d = StStop;
      StStop:  if (stop_tick) state_d = rxs ? StIdle : StBreak;
      StBreak: if (rxs) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output / strobe decode
  always_comb begin
    mid_start  = (state_q == StStart) && tick && (tcnt_q == 4'd7);
    sample_bit = (state_q == StData) && tick && (tcnt_q == 4'd15);
    stop_tick  = (state_q == StStop) && tick && (tcnt_q == 4'd15);
    stop_ok    = stop_tick && rxs;
    stop_bad   = stop_tick && !rxs;
    busy       = (state_q != StIdle);
  end

  // Datapath next-state
  always_comb begin
    pre_d   = pre_q;
    tcnt_d  = tcnt_q;
    bidx_d  = bidx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ss_d    = ss_q;
    valid_d = stop_ok;
    ferr_d  = stop_bad;

    if (state_q == StIdle) begin
      pre_d  = '0;
      tcnt_d = '0;
      bidx_d = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (mid_start) begin
        tcnt_d = '0;
        bidx_d = '0;
      end else if (tick) begin
        tcnt_d = tcnt_q + 4'd1;
      end
    end

    if (sample_bit) begin
      shreg_d = {rxs, shreg_q[7:1]};
      bidx_d  = bidx_q + 3'd1;
    end

    if (stop_ok) begin
      data_d = shreg_q;
      ss_d   = (shreg_q[7:6] == 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= 1'b1;
      rxs     <= 1'b1;
      pre_q   <= '0;
      tcnt_q  <= '0;
      bidx_q  <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      sync1_q <= rxd;
      rxs     <= sync1_q;
      pre_q   <= pre_d;
      tcnt_q  <= tcnt_d;
      bidx_q  <= bidx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ss_q    <= ss_d;
    end
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign frame_err   = ferr_q;
  assign sent_switch = ss_q;

endmodule
